// File: rtl/dds_ctrl_pkg.sv
// Shared defaults, FSM state and request index encoding for the DDS tuning controller.
// Repeat timing defaults exist only when DDS_TUNING_AUTO_REPEAT_EN is defined.
package dds_ctrl_pkg;

  localparam int          FTW_W_DEF       = 32;
  localparam int          PHASE_W_DEF     = 12;
  localparam logic [31:0] FTW_INIT_DEF    = 32'd85899346;
  localparam logic [31:0] FTW_MIN_DEF     = 32'd86;
  localparam logic [31:0] FTW_MAX_DEF     = 32'h7FFF_FFFF;
  localparam logic [31:0] STEP_COARSE_DEF = 32'd85899346;
  localparam logic [31:0] STEP_MICRO_DEF  = 32'd85899;
  localparam logic [31:0] STEP_NANO_DEF   = 32'd86;
  localparam logic [11:0] PHASE_STEP_DEF  = 12'd512;

`ifdef DDS_TUNING_AUTO_REPEAT_EN
  localparam int REPEAT_DLY_DEF = 25000000;
  localparam int REPEAT_PER_DEF = 5000000;
`endif

  typedef enum logic [1:0] {IDLE, WAIT_ACK} state_e;

  typedef enum logic [1:0] {REQ_COARSE, REQ_MICRO, REQ_NANO, REQ_PHASE} req_idx_e;

endpackage

// File: rtl/dds_tuning_ctrl_step_req_gen.sv
// Turns one active-low request level into single-cycle step events (falling edges).
// With DDS_TUNING_AUTO_REPEAT_EN a held request also auto-repeats.
module step_req_gen
`ifdef DDS_TUNING_AUTO_REPEAT_EN
#(
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic reqN,
  output logic stepEvt
);

  logic prevLvl;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) prevLvl <= 1'b0;
    else       prevLvl <= reqN;
  end

`ifdef DDS_TUNING_AUTO_REPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_DLY + 1);
  localparam logic [CNT_W-1:0] DLY_C    = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(REPEAT_DLY - REPEAT_PER + 1);

  logic [CNT_W-1:0] holdCnt;

  // Counts only once armed by a real falling edge, so a line held through reset stays silent.
  always_ff @(posedge clk) begin
    if (reset || reqN)                       holdCnt <= '0;
    else if (holdCnt == DLY_C)               holdCnt <= RELOAD_C;
    else if (prevLvl || (holdCnt != '0))     holdCnt <= holdCnt + 1'b1;
  end

  assign stepEvt = (prevLvl && !reqN) || (!reqN && (holdCnt == DLY_C));
`else
  assign stepEvt = prevLvl && !reqN;
`endif

endmodule

// File: rtl/dds_tuning_ctrl.sv
// DDS tuning word / phase offset controller: step priority, saturation, pending slot, handshake.
// Optional auto-repeat of held requests via DDS_TUNING_AUTO_REPEAT_EN.
module dds_tuning_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int                  FTW_W       = FTW_W_DEF,
  parameter int                  PHASE_W     = PHASE_W_DEF,
  parameter logic [FTW_W-1:0]    FTW_INIT    = FTW_INIT_DEF,
  parameter logic [FTW_W-1:0]    FTW_MIN     = FTW_MIN_DEF,
  parameter logic [FTW_W-1:0]    FTW_MAX     = FTW_MAX_DEF,
  parameter logic [FTW_W-1:0]    STEP_COARSE = STEP_COARSE_DEF,
  parameter logic [FTW_W-1:0]    STEP_MICRO  = STEP_MICRO_DEF,
  parameter logic [FTW_W-1:0]    STEP_NANO   = STEP_NANO_DEF,
  parameter logic [PHASE_W-1:0]  PHASE_STEP  = PHASE_STEP_DEF
`ifdef DDS_TUNING_AUTO_REPEAT_EN
  ,
  parameter int                  REPEAT_DLY  = REPEAT_DLY_DEF,
  parameter int                  REPEAT_PER  = REPEAT_PER_DEF
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coarse_inc_n,
  input  logic               coarse_dec_n,
  input  logic               micro_inc_n,
  input  logic               micro_dec_n,
  input  logic               nano_inc_n,
  input  logic               nano_dec_n,
  input  logic               phase_inc_n,
  input  logic               phase_dec_n,
  output logic [FTW_W-1:0]   ftw,
  output logic [PHASE_W-1:0] phase_off,
  output logic               upd_valid,
  input  logic               upd_ready,
  output logic               sat
);

  logic [3:0] incN, decN, incEvt, decEvt;
  assign incN = {phase_inc_n, nano_inc_n, micro_inc_n, coarse_inc_n};
  assign decN = {phase_dec_n, nano_dec_n, micro_dec_n, coarse_dec_n};

  for (genvar i = 0; i < 4; i++) begin : g_req
    step_req_gen
`ifdef DDS_TUNING_AUTO_REPEAT_EN
      #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
`endif
      uInc (.clk(clk), .reset(reset), .reqN(incN[i]), .stepEvt(incEvt[i]));
    step_req_gen
`ifdef DDS_TUNING_AUTO_REPEAT_EN
      #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
`endif
      uDec (.clk(clk), .reset(reset), .reqN(decN[i]), .stepEvt(decEvt[i]));
  end

  function automatic logic [FTW_W-1:0] stepOf(req_idx_e idx);
    case (idx)
      REQ_COARSE: return STEP_COARSE;
      REQ_MICRO:  return STEP_MICRO;
      default:    return STEP_NANO;
    endcase
  endfunction

  state_e   state;
  logic     pendFtwVld, pendInc, pendPhVld, pendPhInc;
  req_idx_e pendIdx;

  logic           found, curFtwEvt, curInc, curPhEvt, curPhInc;
  req_idx_e       curIdx;
  logic           effFtwEvt, effInc, effPhEvt, effPhInc, clip, ftwChg;
  req_idx_e       effIdx;
  logic [FTW_W:0] stepExt, sumExt, diffExt;
  logic [FTW_W-1:0]   nextFtw;
  logic [PHASE_W-1:0] nextPh;

  // NOTE: every signal gets a default first, so no path through this block infers a latch.
  always_comb begin
    found     = 1'b0;
    curFtwEvt = 1'b0;
    curInc    = 1'b0;
    curIdx    = REQ_COARSE;
    // First pair with any event decides; inc+dec together cancels without falling through.
    for (int p = 0; p < 3; p++) begin
      if (!found && (incEvt[p] || decEvt[p])) begin
        found     = 1'b1;
        curFtwEvt = incEvt[p] ^ decEvt[p];
        curInc    = incEvt[p];
        curIdx    = req_idx_e'(p[1:0]);
      end
    end
    curPhEvt = incEvt[REQ_PHASE] ^ decEvt[REQ_PHASE];
    curPhInc = incEvt[REQ_PHASE];

    // A fresh event supersedes whatever was parked while waiting for the ack.
    effFtwEvt = curFtwEvt || pendFtwVld;
    effInc    = curFtwEvt ? curInc : pendInc;
    effIdx    = curFtwEvt ? curIdx : pendIdx;
    effPhEvt  = curPhEvt || pendPhVld;
    effPhInc  = curPhEvt ? curPhInc : pendPhInc;

    stepExt = {1'b0, stepOf(effIdx)};
    sumExt  = {1'b0, ftw} + stepExt;
    diffExt = {1'b0, ftw} - stepExt;
    nextFtw = ftw;
    clip    = 1'b0;
    if (effFtwEvt) begin
      if (effInc) begin
        if (sumExt > {1'b0, FTW_MAX}) begin nextFtw = FTW_MAX; clip = 1'b1; end
        else                                nextFtw = sumExt[FTW_W-1:0];
      end else begin
        if (diffExt[FTW_W] || (diffExt[FTW_W-1:0] < FTW_MIN)) begin nextFtw = FTW_MIN; clip = 1'b1; end
        else                                                    nextFtw = diffExt[FTW_W-1:0];
      end
    end
    ftwChg = (nextFtw != ftw);

    nextPh = phase_off;
    if (effPhEvt) nextPh = effPhInc ? phase_off + PHASE_STEP : phase_off - PHASE_STEP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ftw        <= FTW_INIT;
      phase_off  <= '0;
      upd_valid  <= 1'b0;
      sat        <= 1'b0;
      pendFtwVld <= 1'b0;
      pendPhVld  <= 1'b0;
    end else begin
      sat <= 1'b0;
      case (state)
        IDLE: begin
          pendFtwVld <= 1'b0;
          pendPhVld  <= 1'b0;
          sat        <= clip;
          if (ftwChg || effPhEvt) begin
            ftw       <= nextFtw;
            phase_off <= nextPh;
            upd_valid <= 1'b1;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (curFtwEvt) pendFtwVld <= 1'b1;
          if (curPhEvt)  pendPhVld  <= 1'b1;
          if (upd_ready) begin
            upd_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: pending payload bits are not reset; they are only consumed while their valid flag is set.
  always_ff @(posedge clk) begin
    if (state == WAIT_ACK) begin
      if (curFtwEvt) begin
        pendInc <= curInc;
        pendIdx <= curIdx;
      end
      if (curPhEvt) pendPhInc <= curPhInc;
    end
  end

endmodule

// File: tb/tb_dds_tuning_ctrl.sv
// Self-checking bench for dds_tuning_ctrl; repeat checks follow DDS_TUNING_AUTO_REPEAT_EN.
`timescale 1ns/1ps
module tb_dds_tuning_ctrl;

  localparam longint FTW_INIT = 85899346;
  localparam longint FTW_MIN  = 86;
  localparam longint FTW_MAX  = 2147483647;
  localparam longint STEP_C   = 85899346;
  localparam longint STEP_M   = 85899;
  localparam longint STEP_N   = 86;
  localparam int     PH_STEP  = 512;
  localparam int     PH_MOD   = 4096;
`ifdef DDS_TUNING_AUTO_REPEAT_EN
  localparam int     R_DLY    = 10;
  localparam int     R_PER    = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  // bit order: 0 coarse_inc, 1 coarse_dec, 2 micro_inc, 3 micro_dec, 4 nano_inc, 5 nano_dec, 6 phase_inc, 7 phase_dec
  logic [7:0]  req = 8'hFF;
  logic        upd_ready = 1'b0;
  logic [31:0] ftw;
  logic [11:0] phase_off;
  logic        upd_valid, sat;

  always #5 clk = ~clk;

`ifdef DDS_TUNING_AUTO_REPEAT_EN
  dds_tuning_ctrl #(.REPEAT_DLY(R_DLY), .REPEAT_PER(R_PER)) dut (
    .clk(clk), .reset(reset),
    .coarse_inc_n(req[0]), .coarse_dec_n(req[1]),
    .micro_inc_n(req[2]),  .micro_dec_n(req[3]),
    .nano_inc_n(req[4]),   .nano_dec_n(req[5]),
    .phase_inc_n(req[6]),  .phase_dec_n(req[7]),
    .ftw(ftw), .phase_off(phase_off),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .sat(sat)
  );
`else
  dds_tuning_ctrl dut (
    .clk(clk), .reset(reset),
    .coarse_inc_n(req[0]), .coarse_dec_n(req[1]),
    .micro_inc_n(req[2]),  .micro_dec_n(req[3]),
    .nano_inc_n(req[4]),   .nano_dec_n(req[5]),
    .phase_inc_n(req[6]),  .phase_dec_n(req[7]),
    .ftw(ftw), .phase_off(phase_off),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .sat(sat)
  );
`endif

  int testsRun = 0;
  int testsFailed = 0;

  // Transaction-level reference: levels -> press events -> signed deltas -> published values.
  bit     mPrev[8];
  int     mAge[8];
  longint mFtw;
  int     mPh;
  bit     mValid, mSat, mBusy, pFtw, pPh;
  longint pFtwD;
  int     pPhD;

  function automatic longint stepOf(int p);
    case (p)
      0:       return STEP_C;
      1:       return STEP_M;
      default: return STEP_N;
    endcase
  endfunction

  task automatic modelStep();
    bit     ev[8];
    bit     fe, pe, chg;
    longint d, t;
    int     pd;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin mPrev[i] = 1'b0; mAge[i] = -1; end
      mFtw = FTW_INIT; mPh = 0; mValid = 0; mSat = 0; mBusy = 0; pFtw = 0; pPh = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      bit low;
      low = !req[i];
      if (mPrev[i] && low)          mAge[i] = 0;
      else if (low && mAge[i] >= 0) mAge[i]++;
      else if (!low)                mAge[i] = -1;
      ev[i] = low && (mAge[i] == 0);
`ifdef DDS_TUNING_AUTO_REPEAT_EN
      if (low && mAge[i] >= R_DLY && ((mAge[i] - R_DLY) % R_PER) == 0) ev[i] = 1'b1;
`endif
      mPrev[i] = !low;
    end
    fe = 0; d = 0;
    for (int p = 0; p < 3; p++) begin
      if (ev[2*p] || ev[2*p+1]) begin
        fe = ev[2*p] ^ ev[2*p+1];
        d  = ev[2*p] ? stepOf(p) : -stepOf(p);
        break;
      end
    end
    pe = ev[6] ^ ev[7];
    pd = ev[6] ? PH_STEP : -PH_STEP;
    mSat = 0;
    if (mBusy) begin
      if (fe) begin pFtw = 1; pFtwD = d; end
      if (pe) begin pPh = 1; pPhD = pd; end
      if (upd_ready) begin mBusy = 0; mValid = 0; end
    end else begin
      if (!fe && pFtw) begin fe = 1; d = pFtwD; end
      if (!pe && pPh)  begin pe = 1; pd = pPhD; end
      pFtw = 0; pPh = 0;
      chg = 0;
      if (fe) begin
        t = mFtw + d;
        if (t > FTW_MAX)      begin t = FTW_MAX; mSat = 1; end
        else if (t < FTW_MIN) begin t = FTW_MIN; mSat = 1; end
        chg  = (t != mFtw);
        mFtw = t;
      end
      if (pe) mPh = ((mPh + pd) % PH_MOD + PH_MOD) % PH_MOD;
      if (chg || pe) begin mBusy = 1; mValid = 1; end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 8'hFF; upd_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      testsRun++;
      if (ftw !== 32'd85899346 || phase_off !== 12'd0 || upd_valid !== 1'b0 || sat !== 1'b0) begin
        testsFailed++;
        $display("FAIL reset_idle cyc%0d: ftw=%0d ph=%0d v=%b s=%b, want 85899346 0 0 0",
                 c, ftw, phase_off, upd_valid, sat);
      end
    end
  endtask

  task automatic test_nano_inc();
    upd_ready = 1'b1;
    req[4] = 1'b0; tick();
    testsRun++;
    if (ftw !== 32'd85899432 || upd_valid !== 1'b1) begin
      testsFailed++;
      $display("FAIL nano_inc: ftw=%0d v=%b, want 85899432 1", ftw, upd_valid);
    end
    tick();
    testsRun++;
    if (upd_valid !== 1'b0) begin
      testsFailed++;
      $display("FAIL nano_valid_pulse: v=%b, want 0", upd_valid);
    end
    req = 8'hFF; tick();
  endtask

  task automatic test_coarse_priority();
    upd_ready = 1'b1;
    req[1] = 1'b0; req[5] = 1'b0; tick();
    testsRun++;
    if (ftw !== 32'd86 || sat !== 1'b0 || upd_valid !== 1'b1) begin
      testsFailed++;
      $display("FAIL coarse_over_nano: ftw=%0d s=%b v=%b, want 86 0 1", ftw, sat, upd_valid);
    end
    req = 8'hFF; tick(); tick();
    req[1] = 1'b0; tick();
    testsRun++;
    if (ftw !== 32'd86 || sat !== 1'b1 || upd_valid !== 1'b0) begin
      testsFailed++;
      $display("FAIL sat_at_min: ftw=%0d s=%b v=%b, want 86 1 0", ftw, sat, upd_valid);
    end
    tick();
    testsRun++;
    if (sat !== 1'b0) begin
      testsFailed++;
      $display("FAIL sat_one_cycle: s=%b, want 0", sat);
    end
    req = 8'hFF; tick();
  endtask

  task automatic test_phase();
    upd_ready = 1'b1;
    req[7] = 1'b0; tick();
    testsRun++;
    if (phase_off !== 12'd3584 || upd_valid !== 1'b1) begin
      testsFailed++;
      $display("FAIL phase_wrap_down: ph=%0d v=%b, want 3584 1", phase_off, upd_valid);
    end
    req = 8'hFF; tick();
    for (int k = 0; k < 8; k++) begin
      req[6] = 1'b0; tick();
      testsRun++;
      if (phase_off !== 12'(mPh) || ftw !== 32'd86) begin
        testsFailed++;
        $display("FAIL phase_inc%0d: ph=%0d ftw=%0d, want %0d 86", k, phase_off, ftw, mPh);
      end
      req = 8'hFF; tick();
    end
    testsRun++;
    if (phase_off !== 12'd3584) begin
      testsFailed++;
      $display("FAIL phase_full_turn: ph=%0d, want 3584", phase_off);
    end
  endtask

  task automatic test_pending();
    longint base;
    base = mFtw;
    upd_ready = 1'b0;
    req[2] = 1'b0; tick();
    testsRun++;
    if (ftw !== 32'(base + STEP_M) || upd_valid !== 1'b1) begin
      testsFailed++;
      $display("FAIL pend_first: ftw=%0d v=%b, want %0d 1", ftw, upd_valid, base + STEP_M);
    end
    for (int k = 0; k < 2; k++) begin
      req = 8'hFF; tick();
      req[2] = 1'b0; tick();
    end
    req = 8'hFF; tick();
    testsRun++;
    if (ftw !== 32'(base + STEP_M) || upd_valid !== 1'b1) begin
      testsFailed++;
      $display("FAIL pend_frozen: ftw=%0d v=%b, want %0d 1", ftw, upd_valid, base + STEP_M);
    end
    upd_ready = 1'b1; tick();
    testsRun++;
    if (upd_valid !== 1'b0) begin
      testsFailed++;
      $display("FAIL pend_ack: v=%b, want 0", upd_valid);
    end
    tick();
    testsRun++;
    if (ftw !== 32'(base + 2 * STEP_M) || upd_valid !== 1'b1) begin
      testsFailed++;
      $display("FAIL pend_apply: ftw=%0d v=%b, want %0d 1", ftw, upd_valid, base + 2 * STEP_M);
    end
    tick();
    testsRun++;
    if (upd_valid !== 1'b0 || ftw !== 32'(base + 2 * STEP_M)) begin
      testsFailed++;
      $display("FAIL pend_single: ftw=%0d v=%b, want %0d 0", ftw, upd_valid, base + 2 * STEP_M);
    end
  endtask

  task automatic test_cancel();
    longint base;
    int     ph0;
    base = mFtw; ph0 = mPh;
    upd_ready = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0; req[2] = 1'b0; tick();
    testsRun++;
    if (ftw !== 32'(base) || upd_valid !== 1'b0) begin
      testsFailed++;
      $display("FAIL pair_cancel: ftw=%0d v=%b, want %0d 0", ftw, upd_valid, base);
    end
    req = 8'hFF; tick();
    req[4] = 1'b0; req[5] = 1'b0; req[6] = 1'b0; tick();
    testsRun++;
    if (ftw !== 32'(base) || phase_off !== 12'((ph0 + PH_STEP) % PH_MOD) || upd_valid !== 1'b1) begin
      testsFailed++;
      $display("FAIL phase_indep: ftw=%0d ph=%0d v=%b, want %0d %0d 1",
               ftw, phase_off, upd_valid, base, (ph0 + PH_STEP) % PH_MOD);
    end
    req = 8'hFF; tick(); tick();
  endtask

  task automatic test_reset_wait_ack();
    upd_ready = 1'b0;
    req[4] = 1'b0; tick();
    req = 8'hFF; tick();
    req[2] = 1'b0; tick();
    req = 8'hFF; reset = 1'b1; tick();
    testsRun++;
    if (upd_valid !== 1'b0 || ftw !== 32'd85899346 || phase_off !== 12'd0) begin
      testsFailed++;
      $display("FAIL reset_in_wait: v=%b ftw=%0d ph=%0d, want 0 85899346 0", upd_valid, ftw, phase_off);
    end
    reset = 1'b0; upd_ready = 1'b1;
    tick(); tick(); tick();
    testsRun++;
    if (upd_valid !== 1'b0 || ftw !== 32'd85899346) begin
      testsFailed++;
      $display("FAIL pending_lost: v=%b ftw=%0d, want 0 85899346", upd_valid, ftw);
    end
  endtask

  task automatic test_hold_through_reset();
    upd_ready = 1'b1;
    req[4] = 1'b0; reset = 1'b1; tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    testsRun++;
    if (ftw !== 32'd85899346 || upd_valid !== 1'b0) begin
      testsFailed++;
      $display("FAIL held_thru_reset: ftw=%0d v=%b, want 85899346 0", ftw, upd_valid);
    end
    req = 8'hFF; tick();
    req[4] = 1'b0; tick();
    testsRun++;
    if (ftw !== 32'd85899432 || upd_valid !== 1'b1) begin
      testsFailed++;
      $display("FAIL step_after_release: ftw=%0d v=%b, want 85899432 1", ftw, upd_valid);
    end
    req = 8'hFF; tick(); tick();
  endtask

  task automatic test_repeat();
    longint base;
    longint steps;
    base = mFtw;
`ifdef DDS_TUNING_AUTO_REPEAT_EN
    steps = 4;
`else
    steps = 1;
`endif
    upd_ready = 1'b1;
    req[4] = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    req = 8'hFF;
    for (int c = 0; c < 5; c++) tick();
    testsRun++;
    if (ftw !== 32'(base + steps * STEP_N) || upd_valid !== 1'b0) begin
      testsFailed++;
      $display("FAIL hold_repeat: ftw=%0d v=%b, want %0d 0", ftw, upd_valid, base + steps * STEP_N);
    end
  endtask

  task automatic test_random();
    int busyLine;
    reset = 1'b1; req = 8'hFF; tick(); reset = 1'b0; tick();
    for (int c = 0; c < 4000; c++) begin
      busyLine = (c < 2000) ? 0 : 1;
      for (int i = 0; i < 8; i++)
        req[i] = ($urandom_range(0, 99) < ((i == busyLine) ? 50 : 8)) ? 1'b0 : 1'b1;
      upd_ready = ($urandom_range(0, 3) != 0);
      tick();
      testsRun++;
      if (ftw !== 32'(mFtw) || phase_off !== 12'(mPh) || upd_valid !== mValid || sat !== mSat) begin
        testsFailed++;
        $display("FAIL random cyc%0d: ftw=%0d ph=%0d v=%b s=%b, want %0d %0d %b %b",
                 c, ftw, phase_off, upd_valid, sat, mFtw, mPh, mValid, mSat);
      end
    end
    req = 8'hFF;
  endtask

  initial begin
    test_reset();
    test_nano_inc();
    test_coarse_priority();
    test_phase();
    test_pending();
    test_cancel();
    test_reset_wait_ack();
    test_hold_through_reset();
    test_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
